// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: operation codes, FSM encoding and
// the access decoder used by mem_lsu.
package mem_lsu_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned AluOpW   = 8;

  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [AluOpW-1:0]   alu_op_t;

  localparam reg_addr_t NOPRegAddr = 5'b00000;

  localparam alu_op_t AluOpLb  = 8'hE0;
  localparam alu_op_t AluOpLh  = 8'hE1;
  localparam alu_op_t AluOpLw  = 8'hE3;
  localparam alu_op_t AluOpLbu = 8'hE4;
  localparam alu_op_t AluOpLhu = 8'hE5;
  localparam alu_op_t AluOpLd  = 8'hE6;
  localparam alu_op_t AluOpSb  = 8'hE8;
  localparam alu_op_t AluOpSh  = 8'hE9;
  localparam alu_op_t AluOpSw  = 8'hEB;
  localparam alu_op_t AluOpSd  = 8'hEC;

  // Value replicated across every LED bit on reset.
  localparam logic LedOff = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2,
    SzDbl  = 2'd3
  } lsu_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    logic      sext;
    lsu_size_e size;
  } lsu_op_t;

  // Doubleword opcodes only decode as accesses on a 64-bit datapath.
  function automatic lsu_op_t decode_op(input alu_op_t op, input logic is64);
    lsu_op_t d;
    d.is_load  = 1'b0;
    d.is_store = 1'b0;
    d.sext     = 1'b0;
    d.size     = SzByte;
    case (op)
      AluOpLb:  begin d.is_load = 1'b1; d.sext = 1'b1; d.size = SzByte; end
      AluOpLbu: begin d.is_load = 1'b1; d.size = SzByte; end
      AluOpLh:  begin d.is_load = 1'b1; d.sext = 1'b1; d.size = SzHalf; end
      AluOpLhu: begin d.is_load = 1'b1; d.size = SzHalf; end
      AluOpLw:  begin d.is_load = 1'b1; d.sext = 1'b1; d.size = SzWord; end
      AluOpLd:  begin d.is_load = is64; d.size = SzDbl; end
      AluOpSb:  begin d.is_store = 1'b1; d.size = SzByte; end
      AluOpSh:  begin d.is_store = 1'b1; d.size = SzHalf; end
      AluOpSw:  begin d.is_store = 1'b1; d.size = SzWord; end
      AluOpSd:  begin d.is_store = is64; d.size = SzDbl; end
      default:  ;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input lsu_size_e size, input logic [2:0] a);
    logic m;
    case (size)
      SzHalf:  m = a[0];
      SzWord:  m = |a[1:0];
      SzDbl:   m = |a[2:0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the LSU: byte enables, store-data replication and load-data
// extraction with sign/zero extension.
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DW = 32,
  localparam int unsigned NB = DW / 8,
  localparam int unsigned OffW = $clog2(NB)
) (
  input  lsu_size_e        size_i,
  input  logic             sext_i,
  input  logic [OffW-1:0]  off_i,
  input  logic [DW-1:0]    sdata_i,
  input  logic [DW-1:0]    rdata_i,
  output logic [NB-1:0]    be_o,
  output logic [DW-1:0]    wdata_o,
  output logic [DW-1:0]    ldata_o
);

  logic [DW-1:0] lane;

  // Addressed byte moved down to bit 0.
  assign lane = rdata_i >> {off_i, 3'b000};

  always_comb begin
    be_o    = '0;
    wdata_o = sdata_i;
    ldata_o = lane;
    unique case (size_i)
      SzByte: begin
        be_o    = NB'(1) << off_i;
        wdata_o = {NB{sdata_i[7:0]}};
        if (sext_i) ldata_o = DW'($signed(lane[7:0]));
        else        ldata_o = DW'(lane[7:0]);
      end
      SzHalf: begin
        be_o    = NB'(2'b11) << off_i;
        wdata_o = {(DW/16){sdata_i[15:0]}};
        if (sext_i) ldata_o = DW'($signed(lane[15:0]));
        else        ldata_o = DW'(lane[15:0]);
      end
      SzWord: begin
        be_o    = NB'(4'hF) << off_i;
        wdata_o = {(DW/32){sdata_i[31:0]}};
        if (sext_i) ldata_o = DW'($signed(lane[31:0]));
        else        ldata_o = DW'(lane[31:0]);
      end
      SzDbl: begin
        be_o    = '1;
        wdata_o = sdata_i;
        ldata_o = lane;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage load/store unit: bus handshake FSM with timeout, misalignment
// detection, and a small MMIO region for LEDs and synchronised switches.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned LED_W  = 16,
  parameter int unsigned SW_W   = 16,
  parameter int unsigned IO_BIT = DW - 1,
  parameter int unsigned TMO    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_addr_t        wd_i,
  input  logic             wreg_i,
  input  logic [DW-1:0]    wdata_i,
  input  alu_op_t          aluop_i,
  input  logic [DW-1:0]    mem_addr_i,
  input  logic [DW-1:0]    reg2_i,
  input  logic [SW_W-1:0]  switch_i,
  output reg_addr_t        wd_o,
  output logic             wreg_o,
  output logic [DW-1:0]    wdata_o,
  output logic             stall_req_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [DW/8-1:0]  mem_be_o,
  output logic [DW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [DW-1:0]    mem_rdata_i,
  output logic [LED_W-1:0] led_o,
  output logic             addr_err_o,
  output logic             bus_err_o
);

  localparam int unsigned NB   = DW / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned CntW = $clog2(TMO + 2);

  lsu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]    addr_q, addr_d, mwdata_q, mwdata_d;
  logic [NB-1:0]    be_q, be_d;
  logic             we_q, we_d;
  lsu_size_e        size_q, size_d;
  logic             sext_q, sext_d;
  logic [OffW-1:0]  off_q, off_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;

  lsu_op_t          op;
  logic             access, mis, is_io, mem_acc, in_wait, ack_hit, tmo_hit, in_idle;
  lsu_size_e        al_size;
  logic             al_sext;
  logic [OffW-1:0]  al_off;
  logic [NB-1:0]    al_be;
  logic [DW-1:0]    al_wdata, al_ldata;

  assign op      = decode_op(aluop_i, DW == 64);
  assign access  = op.is_load | op.is_store;
  assign mis     = access & misaligned(op.size, mem_addr_i[2:0]);
  assign is_io   = mem_addr_i[IO_BIT];
  assign mem_acc = access & ~mis & ~is_io;
  assign in_idle = (state_q == StIdle);
  assign in_wait = (state_q == StWait);
  assign ack_hit = in_wait & mem_ack_i;
  assign tmo_hit = in_wait & ~mem_ack_i & (cnt_q == CntW'(TMO));

  // Lane logic sees live inputs while capturing, latched attributes while extracting.
  assign al_size = in_idle ? op.size : size_q;
  assign al_sext = in_idle ? op.sext : sext_q;
  assign al_off  = in_idle ? mem_addr_i[OffW-1:0] : off_q;

  lsu_align #(
    .DW(DW)
  ) u_align (
    .size_i (al_size),
    .sext_i (al_sext),
    .off_i  (al_off),
    .sdata_i(reg2_i),
    .rdata_i(mem_rdata_i),
    .be_o   (al_be),
    .wdata_o(al_wdata),
    .ldata_o(al_ldata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    mwdata_d = mwdata_q;
    be_d     = be_q;
    we_d     = we_q;
    size_d   = size_q;
    sext_d   = sext_q;
    off_d    = off_q;
    led_d    = led_q;
    case (state_q)
      StIdle: begin
        if (mem_acc) begin
          state_d  = StReq;
          cnt_d    = '0;
          addr_d   = {mem_addr_i[DW-1:OffW], {OffW{1'b0}}};
          mwdata_d = al_wdata;
          be_d     = al_be;
          we_d     = op.is_store;
          size_d   = op.size;
          sext_d   = op.sext;
          off_d    = mem_addr_i[OffW-1:0];
        end
        if (op.is_store && !mis && is_io) led_d = reg2_i[LED_W-1:0];
      end
      StReq: state_d = StWait;
      StWait: begin
        if (ack_hit || tmo_hit) begin
          state_d  = StIdle;
          cnt_d    = '0;
          addr_d   = '0;
          mwdata_d = '0;
          be_d     = '0;
          we_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      mwdata_q  <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      size_q    <= SzByte;
      sext_q    <= 1'b0;
      off_q     <= '0;
      led_q     <= {LED_W{LedOff}};
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      mwdata_q  <= mwdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      off_q     <= off_d;
      led_q     <= led_d;
      sw_meta_q <= switch_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_comb begin
    wd_o        = NOPRegAddr;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    addr_err_o  = 1'b0;
    bus_err_o   = 1'b0;
    // Combinational paths are gated so reset alone forces every output low.
    if (rst) begin
      wd_o        = wd_i;
      wreg_o      = wreg_i;
      wdata_o     = wdata_i;
      stall_req_o = (in_idle & mem_acc) | (state_q == StReq) | (in_wait & ~mem_ack_i & ~tmo_hit);
      bus_err_o   = tmo_hit;
      if (mis) begin
        addr_err_o = 1'b1;
        wreg_o     = 1'b0;
      end else if (access && is_io) begin
        wreg_o = wreg_i & op.is_load;
        if (op.is_load) wdata_o = DW'(sw_sync_q);
      end else if (access) begin
        wreg_o  = wreg_i & op.is_load & ack_hit;
        wdata_o = al_ldata;
      end
    end
  end

  assign mem_req_o   = (state_q == StReq);
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = mwdata_q;
  assign led_o       = led_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: single-cycle vector table, bus-access table and
// hand-written MMIO/synchroniser and mid-access reset sequences.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned LED_W = 16;
  localparam int unsigned SW_W  = 16;
  localparam int unsigned TMO   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  reg_addr_t        wd_i = '0;
  logic             wreg_i = 1'b0;
  logic [DW-1:0]    wdata_i = '0;
  alu_op_t          aluop_i = '0;
  logic [DW-1:0]    mem_addr_i = '0;
  logic [DW-1:0]    reg2_i = '0;
  logic [SW_W-1:0]  switch_i = '0;
  reg_addr_t        wd_o;
  logic             wreg_o;
  logic [DW-1:0]    wdata_o;
  logic             stall_req_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [DW/8-1:0]  mem_be_o;
  logic [DW-1:0]    mem_addr_o;
  logic [DW-1:0]    mem_wdata_o;
  logic             mem_ack_i = 1'b0;
  logic [DW-1:0]    mem_rdata_i = '0;
  logic [LED_W-1:0] led_o;
  logic             addr_err_o;
  logic             bus_err_o;

  mem_lsu #(
    .DW    (DW),
    .LED_W (LED_W),
    .SW_W  (SW_W),
    .IO_BIT(DW - 1),
    .TMO   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .aluop_i    (aluop_i),
    .mem_addr_i (mem_addr_i),
    .reg2_i     (reg2_i),
    .switch_i   (switch_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stall_req_o(stall_req_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_be_o   (mem_be_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .led_o      (led_o),
    .addr_err_o (addr_err_o),
    .bus_err_o  (bus_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    alu_op_t     op;
    logic [31:0] addr;
    reg_addr_t   wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        exp_wreg;
    logic        chk_wdata;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } io_vec_t;

  typedef struct {
    string       name;
    alu_op_t     op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    int          ack_after;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_mwdata;
    int          exp_stall;
    logic        exp_wreg;
    logic [31:0] exp_wdata;
    logic        exp_berr;
  } mem_vec_t;

  io_vec_t  iov[8];
  mem_vec_t mv[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_stall;
    int  n_req;
    bit  done;

    iov[0] = '{"pass_nop",  8'h00,    32'h0000_0003, 5'd3,  1'b1, 32'hDEAD_BEEF,
               1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0};
    iov[1] = '{"pass_alu",  8'h11,    32'h0000_0000, 5'd31, 1'b0, 32'h0F0F_0F0F,
               1'b0, 1'b1, 32'h0F0F_0F0F, 1'b0};
    iov[2] = '{"lw_mis",    AluOpLw,  32'h0000_0006, 5'd4,  1'b1, 32'h5555_5555,
               1'b0, 1'b0, 32'h0,         1'b1};
    iov[3] = '{"lh_mis",    AluOpLh,  32'h0000_0003, 5'd4,  1'b1, 32'h5555_5555,
               1'b0, 1'b0, 32'h0,         1'b1};
    iov[4] = '{"sw_mis",    AluOpSw,  32'h0000_0002, 5'd4,  1'b1, 32'h5555_5555,
               1'b0, 1'b0, 32'h0,         1'b1};
    iov[5] = '{"sh_mis_io", AluOpSh,  32'h8000_0001, 5'd4,  1'b1, 32'h5555_5555,
               1'b0, 1'b0, 32'h0,         1'b1};
    iov[6] = '{"ld_on_32",  AluOpLd,  32'h0000_0000, 5'd6,  1'b1, 32'h2468_1357,
               1'b1, 1'b1, 32'h2468_1357, 1'b0};
    iov[7] = '{"lb_io",     AluOpLb,  32'h8000_0003, 5'd8,  1'b1, 32'h9999_9999,
               1'b1, 1'b1, 32'h0000_0000, 1'b0};

    mv[0] = '{"lb_neg", AluOpLb,  32'h0000_0003, 32'h0, 32'h80FF_1234, 2,
              32'h0000_0000, 4'b1000, 1'b0, 32'h0, 4, 1'b1, 32'hFFFF_FF80, 1'b0};
    mv[1] = '{"sh_st",  AluOpSh,  32'h0000_0102, 32'h0000_ABCD, 32'h0, 0,
              32'h0000_0100, 4'b1100, 1'b1, 32'hABCD_ABCD, 2, 1'b0, 32'h0, 1'b0};
    mv[2] = '{"lhu",    AluOpLhu, 32'h0000_0002, 32'h0, 32'h8001_0000, 1,
              32'h0000_0000, 4'b1100, 1'b0, 32'h0, 3, 1'b1, 32'h0000_8001, 1'b0};
    mv[3] = '{"lh",     AluOpLh,  32'h0000_0002, 32'h0, 32'h8001_0000, 0,
              32'h0000_0000, 4'b1100, 1'b0, 32'h0, 2, 1'b1, 32'hFFFF_8001, 1'b0};
    mv[4] = '{"lw",     AluOpLw,  32'h0000_0010, 32'h0, 32'hCAFE_BABE, 1,
              32'h0000_0010, 4'b1111, 1'b0, 32'h0, 3, 1'b1, 32'hCAFE_BABE, 1'b0};
    mv[5] = '{"sb",     AluOpSb,  32'h0000_0041, 32'h1234_5677, 32'h0, 0,
              32'h0000_0040, 4'b0010, 1'b1, 32'h7777_7777, 2, 1'b0, 32'h0, 1'b0};
    mv[6] = '{"lbu",    AluOpLbu, 32'h0000_0006, 32'h0, 32'h00AB_0000, 3,
              32'h0000_0004, 4'b0100, 1'b0, 32'h0, 5, 1'b1, 32'h0000_00AB, 1'b0};
    mv[7] = '{"sw_top", AluOpSw,  32'h7FFF_FFFC, 32'h1357_2468, 32'h0, 0,
              32'h7FFF_FFFC, 4'b1111, 1'b1, 32'h1357_2468, 2, 1'b0, 32'h0, 1'b0};
    mv[8] = '{"lw_tmo", AluOpLw,  32'h0000_0020, 32'h0, 32'h0, -1,
              32'h0000_0020, 4'b1111, 1'b0, 32'h0, 6, 1'b0, 32'h0, 1'b1};

    // Reset with a live memory access and active switches on the inputs.
    aluop_i    = AluOpLw;
    mem_addr_i = 32'h0000_0020;
    wd_i       = 5'd5;
    wreg_i     = 1'b1;
    wdata_i    = 32'hABCD_EF01;
    switch_i   = 16'hFFFF;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wd",     wd_o,          NOPRegAddr);
    chk("rst_wreg",   wreg_o,        0);
    chk("rst_wdata",  wdata_o,       0);
    chk("rst_stall",  stall_req_o,   0);
    chk("rst_req",    mem_req_o,     0);
    chk("rst_addr",   mem_addr_o,    0);
    chk("rst_led",    led_o,         0);
    chk("rst_sync",   dut.sw_sync_q, 0);
    chk("rst_state",  dut.state_q,   StIdle);
    switch_i = '0;
    @(negedge clk);
    rst     = 1'b1;
    aluop_i = 8'h00;
    @(negedge clk);

    // Single-cycle outcomes: pass-through, misalignment and MMIO loads.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      aluop_i    = iov[i].op;
      mem_addr_i = iov[i].addr;
      wd_i       = iov[i].wd;
      wreg_i     = iov[i].wreg;
      wdata_i    = iov[i].wdata;
      reg2_i     = 32'h0000_1111;
      #1;
      chk({iov[i].name, "_wd"},    wd_o,        iov[i].wd);
      chk({iov[i].name, "_wreg"},  wreg_o,      iov[i].exp_wreg);
      chk({iov[i].name, "_err"},   addr_err_o,  iov[i].exp_err);
      chk({iov[i].name, "_stall"}, stall_req_o, 0);
      if (iov[i].chk_wdata) chk({iov[i].name, "_wdata"}, wdata_o, iov[i].exp_wdata);
      @(negedge clk);
      chk({iov[i].name, "_noreq"}, mem_req_o, 0);
      chk({iov[i].name, "_led"},   led_o,     0);
    end

    // Bus accesses: handshake timing, lane logic, extension and timeout.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      aluop_i     = mv[i].op;
      mem_addr_i  = mv[i].addr;
      reg2_i      = mv[i].reg2;
      wd_i        = 5'd9;
      wreg_i      = 1'b1;
      wdata_i     = 32'h1111_1111;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'hDEAD_DEAD;
      n_stall     = 0;
      n_req       = 0;
      done        = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        if (mv[i].ack_after >= 0 && c == mv[i].ack_after + 2) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mv[i].rdata;
        end
        #1;
        if (mem_req_o) n_req++;
        if (c == 1) begin
          chk({mv[i].name, "_req"},  mem_req_o,  1);
          chk({mv[i].name, "_addr"}, mem_addr_o, mv[i].exp_addr);
          chk({mv[i].name, "_be"},   mem_be_o,   mv[i].exp_be);
          chk({mv[i].name, "_we"},   mem_we_o,   mv[i].exp_we);
          if (mv[i].exp_we) chk({mv[i].name, "_mwdata"}, mem_wdata_o, mv[i].exp_mwdata);
        end
        if (!stall_req_o) begin
          done = 1'b1;
          chk({mv[i].name, "_addr_end"}, mem_addr_o, mv[i].exp_addr);
          chk({mv[i].name, "_be_end"},   mem_be_o,   mv[i].exp_be);
          chk({mv[i].name, "_wreg"},     wreg_o,     mv[i].exp_wreg);
          chk({mv[i].name, "_berr"},     bus_err_o,  mv[i].exp_berr);
          if (mv[i].exp_wreg) chk({mv[i].name, "_wdata"}, wdata_o, mv[i].exp_wdata);
        end else begin
          n_stall++;
          @(negedge clk);
        end
      end
      chk({mv[i].name, "_finished"}, done,    1);
      chk({mv[i].name, "_nstall"},   n_stall, mv[i].exp_stall);
      chk({mv[i].name, "_nreq"},     n_req,   1);
      @(negedge clk);
      mem_ack_i = 1'b0;
      aluop_i   = 8'h00;
      #1;
      chk({mv[i].name, "_idle"},     dut.state_q, StIdle);
      chk({mv[i].name, "_berr_off"}, bus_err_o,   0);
    end

    // MMIO store to LEDs, then switch reads through the synchroniser.
    @(negedge clk);
    aluop_i    = AluOpSw;
    mem_addr_i = 32'h8000_0000;
    reg2_i     = 32'h0000_5A5A;
    wd_i       = 5'd2;
    wreg_i     = 1'b1;
    #1;
    chk("io_sw_stall", stall_req_o, 0);
    chk("io_sw_wreg",  wreg_o,      0);
    chk("io_sw_led0",  led_o,       0);
    @(negedge clk);
    aluop_i  = 8'h00;
    switch_i = 16'h00F0;
    #1;
    chk("io_sw_led1",  led_o,       16'h5A5A);
    chk("io_sw_noreq", mem_req_o,   0);
    repeat (3) @(negedge clk);
    aluop_i = AluOpLw;
    #1;
    chk("io_lw_wdata", wdata_o,     32'h0000_00F0);
    chk("io_lw_wreg",  wreg_o,      1);
    chk("io_lw_stall", stall_req_o, 0);
    switch_i = 16'h0F0F;
    @(negedge clk);
    #1 chk("io_sync_1", wdata_o, 32'h0000_00F0);
    @(negedge clk);
    #1 chk("io_sync_2", wdata_o, 32'h0000_0F0F);

    // Reset dropped in WAIT; a later ack must have no effect.
    @(negedge clk);
    aluop_i    = AluOpLw;
    mem_addr_i = 32'h0000_0020;
    wd_i       = 5'd9;
    @(negedge clk);
    @(negedge clk);
    #1 chk("mid_in_wait", dut.state_q, StWait);
    #2 rst = 1'b0;
    #1;
    chk("mid_state", dut.state_q, StIdle);
    chk("mid_req",   mem_req_o,   0);
    chk("mid_stall", stall_req_o, 0);
    chk("mid_addr",  mem_addr_o,  0);
    chk("mid_be",    mem_be_o,    0);
    chk("mid_led",   led_o,       0);
    chk("mid_wd",    wd_o,        NOPRegAddr);
    chk("mid_wreg",  wreg_o,      0);
    chk("mid_cnt",   dut.cnt_q,   0);
    @(negedge clk);
    rst       = 1'b1;
    aluop_i   = 8'h00;
    wd_i      = 5'd3;
    wreg_i    = 1'b1;
    wdata_i   = 32'h0000_0077;
    mem_ack_i = 1'b1;
    #1;
    chk("late_ack_stall", stall_req_o, 0);
    chk("late_ack_wdata", wdata_o,     32'h0000_0077);
    chk("late_ack_berr",  bus_err_o,   0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    chk("late_ack_state", dut.state_q, StIdle);
    chk("late_ack_req",   mem_req_o,   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
